aes_decrypt_iter: RTL

//  Iterative AES-256 decryptor: the receive-side counterpart of the encrypt pipeline.

---
 rtl/aes_decrypt_iter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter
//   Iterative AES-256 decryptor. One ciphertext block is loaded and whitened
//   with key[NR]. One inverse round then runs per clock, using round keys
//   key[NR-1] down to key[1]. A final round without InvMixColumns applies
//   key[0]. The round keys are the ordinary encryption schedule, so no
//   inverse key schedule is needed.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     synchronous active-low reset
//     ready     a block is present on data_in
//     data_in   ciphertext, bit 127 = byte 0 (column-major state order)
//     key       round keys key[0]..key[NR], held stable while a block is in flight
//     data_out  plaintext, held until the next completion
//     valid     one-cycle pulse when data_out has just been updated
//     busy      a block offered on ready this cycle would be dropped
//
//   Build option: AES_DEC_INBUF_EN adds a one-entry input holding register.
//   A block that arrives while the engine is running is parked in it and
//   starts on the same edge as the previous block's final round. In that build
//   busy means "holding register full".

module aes_decrypt_iter #(
    parameter int NR = 14,
    parameter int RW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ready,
    input  logic [127:0]       data_in,
    input  logic [NR:0][127:0] key,
    output logic [127:0]       data_out,
    output logic               valid,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_t;

    state_t        state;
    logic [RW-1:0] round;
    logic [127:0]  st;
    logic [127:0]  inv_core;
    logic [127:0]  round_next;
    logic [127:0]  final_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply over exponent 11111110b);
    // this maps 0 to 0, which is what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 0; i < 8; i++) begin
            r = gmul(r, r);
            if (i < 7) r = gmul(r, x);
        end
        return r;
    endfunction

    // Inverse affine transform (rotations by 2, 5 and 7, constant 0x05), then inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned k = 0; k < 16; k++)
            o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
        return o;
    endfunction

    // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
        return o;
    endfunction

    // Multiplies by one of the small constants 09/0b/0d/0e, built from xtime powers.
    function automatic logic [7:0] cmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^ (c[0] ? a  : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = cmul(a0, 4'he) ^ cmul(a1, 4'hb) ^ cmul(a2, 4'hd) ^ cmul(a3, 4'h9);
            o[119 - 32*c -: 8] = cmul(a0, 4'h9) ^ cmul(a1, 4'he) ^ cmul(a2, 4'hb) ^ cmul(a3, 4'hd);
            o[111 - 32*c -: 8] = cmul(a0, 4'hd) ^ cmul(a1, 4'h9) ^ cmul(a2, 4'he) ^ cmul(a3, 4'hb);
            o[103 - 32*c -: 8] = cmul(a0, 4'hb) ^ cmul(a1, 4'hd) ^ cmul(a2, 4'h9) ^ cmul(a3, 4'he);
        end
        return o;
    endfunction

    // The middle rounds and the final round share InvSubBytes(InvShiftRows(st)).
    always_comb begin
        inv_core   = inv_sub_bytes(inv_shift_rows(st));
        round_next = inv_mix_columns(inv_core ^ key[round]);
        final_next = inv_core ^ key[0];
    end

`ifdef AES_DEC_INBUF_EN
    logic [127:0] hold_data;
    logic         hold_full;

    assign busy = hold_full;
`else
    logic         busy_r;

    assign busy = busy_r;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            round    <= '0;
            st       <= '0;
            data_out <= '0;
            valid    <= 1'b0;
`ifdef AES_DEC_INBUF_EN
            hold_data <= '0;
            hold_full <= 1'b0;
`else
            busy_r    <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
`ifdef AES_DEC_INBUF_EN
                    // A block parked during the previous final round starts here first.
                    if (hold_full) begin
                        st        <= hold_data ^ key[NR];
                        round     <= RW'(NR - 1);
                        state     <= ROUND;
                        hold_full <= 1'b0;
                    end else if (ready) begin
                        st    <= data_in ^ key[NR];
                        round <= RW'(NR - 1);
                        state <= ROUND;
                    end
`else
                    busy_r <= ready;
                    if (ready) begin
                        st    <= data_in ^ key[NR];
                        round <= RW'(NR - 1);
                        state <= ROUND;
                    end
`endif
                end
                ROUND: begin
                    st    <= round_next;
                    round <= round - RW'(1);
                    if (round == RW'(1)) state <= FINAL;
`ifdef AES_DEC_INBUF_EN
                    if (ready && !hold_full) begin
                        hold_data <= data_in;
                        hold_full <= 1'b1;
                    end
`endif
                end
                FINAL: begin
                    data_out <= final_next;
                    valid    <= 1'b1;
`ifdef AES_DEC_INBUF_EN
                    if (hold_full) begin
                        st        <= hold_data ^ key[NR];
                        round     <= RW'(NR - 1);
                        state     <= ROUND;
                        hold_full <= 1'b0;
                    end else begin
                        state <= IDLE;
                        if (ready) begin
                            hold_data <= data_in;
                            hold_full <= 1'b1;
                        end
                    end
`else
                    // busy_r stays set so that busy covers the valid cycle.
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
